imem_loader: RTL

Boot-time program loader for the 512×32 instruction memory. It accepts a byte stream on a valid/ready handshake and packs it into big-endian 32-bit words. Each word goes to the memory's write port at consecutive word addresses starting at 0. The processor is held in reset from power-up until the requested number of words has been written.

---
 rtl/imem_pkg.sv | 28 ++
 rtl/imem_word_pack.sv | 50 +++++
 rtl/imem_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory boot loader.
//   state_e      - loader FSM states
//   IMEM_SIZE    - instruction memory depth in words
//   IMEM_ADDR_W  - word-address width
//   BE_LANE_LSB0 - bit position of the first (most significant) byte of a word
//   lane_lsb()   - LSB position of byte index 0..3 in a big-endian word
`timescale 1ns/1ps
package imem_pkg;

  localparam int IMEM_SIZE   = 512;
  localparam int IMEM_ADDR_W = 9;

  // Byte index 0 lands in [31:24]; each later byte moves one lane down.
  localparam logic [4:0] BE_LANE_LSB0 = 5'd24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic [4:0] lane_lsb(input logic [1:0] idx);
    return BE_LANE_LSB0 - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/imem_word_pack.sv
// imem_word_pack: packs accepted bytes into a big-endian 32-bit word.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   clear_i      - restart packing at byte 0 and zero the word
//   accept_i     - a byte is taken this cycle
//   byte_i       - byte value
//   word_o       - assembled word (registered)
//   word_done_o  - the 4th byte of a word is being accepted this cycle
`timescale 1ns/1ps
module imem_word_pack
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (accept_i) begin
      word_d[lane_lsb(idx_q) +: 8] = byte_i;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = accept_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams bytes into the instruction memory
// as big-endian words at addresses 0..N-1 and holds the CPU in reset until done.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum word).
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   start, word_count       - load request and word count (0 or >MEM_SIZE -> MEM_SIZE)
//   byte_valid, byte_data   - byte source
//   byte_ready              - byte accepted when valid && ready
//   mem_we, mem_addr, mem_din - instruction memory write port
//   busy, done, cpu_hold    - load status, processor reset hold
//   chk_err                 - checksum mismatch (0 without the macro)
`timescale 1ns/1ps
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_SIZE = IMEM_SIZE,
  parameter int ADDR_W   = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              chk_err
);

  localparam logic [ADDR_W:0] N_MAX = (ADDR_W+1)'(MEM_SIZE);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              load_start;
  logic              accept;
  logic              word_done;
  logic [31:0]       word;

  assign load_start = start && ((state_q == IDLE) || (state_q == DONE));
  assign byte_ready = (state_q == RECV) || (state_q == CHECK);
  assign accept     = byte_valid && byte_ready;

  imem_word_pack u_pack (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (load_start),
    .accept_i    (accept),
    .byte_i      (byte_data),
    .word_o      (word),
    .word_done_o (word_done)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic        chk_err_q, chk_err_d;
  logic [31:0] xor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
    end else if (load_start) begin
      xor_q <= '0;
    end else if (state_q == WRITE) begin
      xor_q <= xor_q ^ word;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_err_d = chk_err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RECV;
          n_d     = ((word_count == '0) || (word_count > N_MAX)) ? N_MAX : word_count;
          cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_err_d = 1'b0;
`endif
        end
      end
      RECV: begin
        if (word_done) state_d = WRITE;
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q + 1'b1 == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        // The last checksum byte is still on byte_data, so compare the word
        // as it will look after this byte lands in [7:0].
        if (word_done) begin
          state_d   = DONE;
          chk_err_d = ({word[31:8], byte_data} != xor_q);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_we   = (state_q == WRITE);
  assign mem_addr = cnt_q[ADDR_W-1:0];
  assign mem_din  = word;
  assign busy     = (state_q == RECV) || (state_q == WRITE) || (state_q == CHECK);
  assign done     = (state_q == DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else        chk_err_q <= chk_err_d;
  end

  assign chk_err  = chk_err_q;
  assign cpu_hold = !((state_q == DONE) && !chk_err_q);
`else
  assign chk_err  = 1'b0;
  assign cpu_hold = (state_q != DONE);
`endif

endmodule
